// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state type, rate/size helpers and frame constants.
// Shared between the word transmitter and the receiver.
// Optional macro UART_PARITY_EN adds the PARITY state (even parity per byte).
package uart_pkg;

    localparam int   DATA_BITS = 8;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_PARITY_EN
        PARITY,
`endif
        STOP
    } uart_state_t;

    // Clocks per serial bit from the clock and bit-rate units.
    function automatic int calc_cpb(input int if_unit, input int uf_unit);
        return if_unit / uf_unit;
    endfunction

    // Number of bytes needed to carry a word of w bits.
    function automatic int calc_nb(input int w);
        return (w + DATA_BITS - 1) / DATA_BITS;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: pulses tick for one cycle on the last cycle of every CPB-cycle bit.
// Held at zero while disabled and restarted when a new word is accepted.
module uart_baud_tick #(
    parameter int CPB = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    input  logic enable,
    output logic tick
);

    localparam int CW = (CPB > 1) ? $clog2(CPB) : 1;

    logic [CW-1:0] cnt_reg;

    assign tick = enable && (cnt_reg == CW'(CPB - 1));

    // Count clocks within the current bit; wrap on tick, clear on reset/restart.
    always_ff @(posedge clock) begin
        if (reset || restart) begin
            cnt_reg <= '0;
        end else if (enable) begin
            if (tick) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + CW'(1);
            end
        end else begin
            cnt_reg <= '0;
        end
    end

endmodule

// File: rtl/uart_word_tx.sv
// Word-wide UART transmitter: sends a W-bit word as ceil(W/8) back-to-back
// frames, least-significant byte first, high bits of a short last byte as 0.
// Optional macro UART_PARITY_EN inserts an even-parity bit before each stop bit.
module uart_word_tx
    import uart_pkg::*;
#(
    parameter int IF = 2,
    parameter int UF = 1,
    parameter int W  = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] data,
    input  logic         start,
    output logic         tx,
    output logic         busy,
    output logic         done
);

    localparam int CPB    = calc_cpb(IF, UF);
    localparam int NB     = calc_nb(W);
    localparam int PAD_W  = NB * DATA_BITS;
    localparam int BYTE_W = (NB > 1) ? $clog2(NB) : 1;

    uart_state_t       state_reg, state_next;
    logic [PAD_W-1:0]  shift_reg, shift_next;
    logic [2:0]        bit_cnt_reg, bit_cnt_next;
    logic [BYTE_W-1:0] byte_cnt_reg, byte_cnt_next;
`ifdef UART_PARITY_EN
    logic              parity_reg, parity_next;
`endif

    logic [PAD_W-1:0]  data_pad;
    logic              accept;
    logic              tick;

    // Zero-extend the word to a whole number of bytes.
    generate
        for (genvar gi = 0; gi < PAD_W; gi++) begin : g_pad
            if (gi < W) begin : g_data
                assign data_pad[gi] = data[gi];
            end else begin : g_zero
                assign data_pad[gi] = 1'b0;
            end
        end
    endgenerate

    assign accept = (state_reg == IDLE) && start;
    assign busy   = (state_reg != IDLE);

    uart_baud_tick #(
        .CPB(CPB)
    ) u_baud_tick (
        .clock  (clock),
        .reset  (reset),
        .restart(accept),
        .enable (busy),
        .tick   (tick)
    );

    // State, shift register and counters; reset aborts any frame in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= IDLE;
            shift_reg    <= '0;
            bit_cnt_reg  <= '0;
            byte_cnt_reg <= '0;
`ifdef UART_PARITY_EN
            parity_reg   <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            shift_reg    <= shift_next;
            bit_cnt_reg  <= bit_cnt_next;
            byte_cnt_reg <= byte_cnt_next;
`ifdef UART_PARITY_EN
            parity_reg   <= parity_next;
`endif
        end
    end

    // Next-state logic and line/done outputs; every bit advances on tick.
    always_comb begin
        state_next    = state_reg;
        shift_next    = shift_reg;
        bit_cnt_next  = bit_cnt_reg;
        byte_cnt_next = byte_cnt_reg;
`ifdef UART_PARITY_EN
        parity_next   = parity_reg;
`endif
        tx            = STOP_BIT;
        done          = 1'b0;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next    = START;
                    shift_next    = data_pad;
                    bit_cnt_next  = '0;
                    byte_cnt_next = '0;
                end
            end
            START: begin
                tx = START_BIT;
                if (tick) begin
                    state_next   = DATA;
                    bit_cnt_next = '0;
`ifdef UART_PARITY_EN
                    parity_next  = 1'b0;
`endif
                end
            end
            DATA: begin
                tx = shift_reg[0];
                if (tick) begin
                    shift_next   = shift_reg >> 1;
                    bit_cnt_next = bit_cnt_reg + 3'd1;
`ifdef UART_PARITY_EN
                    parity_next  = parity_reg ^ shift_reg[0];
`endif
                    if (bit_cnt_reg == 3'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                tx = parity_reg;
                if (tick) begin
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                tx = STOP_BIT;
                if (tick) begin
                    if (byte_cnt_reg == BYTE_W'(NB - 1)) begin
                        state_next = IDLE;
                        done       = 1'b1;
                    end else begin
                        state_next    = START;
                        byte_cnt_next = byte_cnt_reg + BYTE_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: doc/uart_word_tx.md
UART_WORD_TX -- requirements
Module: uart_word_tx

Interface
REQ-001 SHALL have parameter IF, default 2: input clock frequency unit; clocks per bit CPB = IF/UF.
REQ-002 SHALL have parameter UF, default 1: UART bit-rate unit; IF SHALL be an integer multiple of UF, with IF/UF >= 1.
REQ-003 SHALL have parameter W, default 16: word width in bits; NB = ceil(W/8) bytes per word.
REQ-004 clock  input  1  single system clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 data  input  W  word to send; sampled only on an accepted start.
REQ-007 start  input  1  send request; accepted only when busy=0.
REQ-008 tx  output  1  serial line; idle high.
REQ-009 busy  output  1  high from the cycle after acceptance until the last stop bit ends.
REQ-010 done  output  1  one-cycle pulse when the whole word has been sent.

Function
REQ-011 SHALL latch data into an internal shift register on the edge where start=1 and busy=0; busy=1 and tx=0 (start bit) from the next cycle.
REQ-012 SHALL send NB frames back-to-back, least-significant byte first; bits of a short final byte above W SHALL be sent as 0.
REQ-013 Each frame SHALL be: start bit 0, 8 data bits LSB first, [parity bit], stop bit 1; no idle gap between frames.
REQ-014 Each bit SHALL hold tx for exactly CPB clock cycles.
REQ-015 FSM states: IDLE, START, DATA, PARITY, STOP. IDLE->START on accept; START->DATA after CPB cycles; DATA->PARITY (or STOP) after 8 bits; PARITY->STOP; STOP->START if bytes remain, else IDLE.
REQ-016 Word duration SHALL be NB*(10+P)*CPB cycles, P=1 with parity else 0.
REQ-017 On the final cycle of the last stop bit done SHALL pulse 1 and busy SHALL fall on the next edge.
REQ-018 start while busy=1 SHALL be ignored; the word in flight SHALL not be affected.
REQ-019 start held high continuously SHALL start a new word on the first cycle busy=0, giving back-to-back words without an idle bit.
REQ-020 Changes on data while busy=1 SHALL not affect tx.

Reset
REQ-021 On reset: tx=1, busy=0, done=0, FSM=IDLE, and all counters cleared.
REQ-022 Reset mid-frame SHALL abort the frame: tx=1 from the next cycle, with no done pulse.
REQ-023 Reset SHALL take priority over a start in the same cycle.

Configuration
REQ-024 Macro UART_PARITY_EN: when defined, an even-parity bit (XOR of the 8 data bits) is inserted before each stop bit.
REQ-025 Without UART_PARITY_EN, there is no PARITY state and the frame is 10 bits; the port list is identical in both builds.

Structure
REQ-026 Package uart_pkg SHALL hold the FSM state typedef, the CPB and NB computation functions, and the constants DATA_BITS=8, START_BIT=0 and STOP_BIT=1; uart_pkg is shared with the receiver.
REQ-027 One sub-module, uart_baud_tick, SHALL generate a one-cycle tick every CPB cycles; it is restarted on acceptance.

Verification (W=16, IF=2, UF=1, CPB=2 unless stated)
REQ-028 Send 16'h1234 with no parity: tx carries 0x34 then 0x12, busy is high for 40 cycles, and done pulses once at cycle 40.
REQ-029 Loopback into uart_receiver (W=16) with data 16'h0F0F: the receiver asserts valid with 16'h0F0F.
REQ-030 Pulse start at cycle 10 of a word in flight: no effect, and the tx sequence is bit-identical to an undisturbed run.
REQ-031 Assert reset at cycle 15 of a word: tx=1 next cycle, busy=0, no done pulse; a following start of 16'hFFFF sends cleanly.
REQ-032 With UART_PARITY_EN, send 16'h0034: parity bits are 1 (0x34) then 0 (0x00), and busy is high 44 cycles.
REQ-033 With W=12, send 12'hABC: bytes 0xBC then 0x0A; with start held high, a second word begins the cycle after busy falls.
